rename_table: RTL
=================

RENAME_TABLE -- requirements
Module: rename_table

Interface
REQ-001 SHALL have parameter NRREG, default 32: number of architectural registers; register 0 is hardwired.
REQ-002 SHALL have parameter BITWIDTH, default 32: width of an entry value.
REQ-003 SHALL have parameter TAG_W, default 6: width of a reservation/ROB tag.
REQ-004 SHALL have parameters NRREAD = 4 (read ports), NRRENAME = 2 (rename ports), NRCDB = 2 (CDB broadcast ports) and NRCKPT = 4 (checkpoint slots).
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have ports rd_addr[NRREAD], input, log2(NRREG) bits each: read register index.
REQ-008 SHALL have ports rd_data[NRREAD], output, RAT_t each: entry read.
REQ-009 SHALL have ports ren_valid[NRRENAME] (input, 1), ren_addr[NRRENAME] (input, log2(NRREG)) and ren_tag[NRRENAME] (input, TAG_W): rename requests.
REQ-010 SHALL have ports cdb_valid[NRCDB] (input, 1), cdb_tag[NRCDB] (input, TAG_W) and cdb_value[NRCDB] (input, BITWIDTH): result broadcasts.
REQ-011 SHALL have ports ckpt_req (input, 1), ckpt_id (output, log2(NRCKPT)) and ckpt_full (output, 1): checkpoint allocation.
REQ-012 SHALL have ports ckpt_release (input, 1): frees the oldest checkpoint; restore_valid (input, 1) and restore_id (input, log2(NRCKPT)): mispredict rollback.
REQ-013 SHALL have port ckpt_count, output, log2(NRCKPT)+1 bits: number of live checkpoints.

Function
- REQ-014 Entry semantics: Valid=1 means Value is usable; Valid=0 means the value is pending on Tag.
- REQ-015 rd_data SHALL be combinational from the current table, with zero-cycle forwarding: a pending entry whose Tag matches any valid cdb_tag returns Valid=1 and that cdb_value.
- REQ-016 Reads SHALL NOT see same-cycle renames; intra-group dependencies are the decoder's responsibility.
- REQ-017 rd_addr=0 SHALL return Valid=1, Tag=0, Value=0; renames of register 0 SHALL be ignored.
- REQ-018 A rename SHALL set the entry to Valid=0, Tag=ren_tag on the next clock edge.
- REQ-019 When several rename ports target the same register, the highest-index port SHALL win.
- REQ-020 A CDB broadcast SHALL set Valid=1 and Value=cdb_value on every pending entry with a matching Tag, in the table and in all live snapshots.
- REQ-021 If a rename and a CDB hit the same entry in the same cycle, the rename SHALL win.
- REQ-022 If two CDB ports carry the same tag, the lower-index port SHALL win; the producer guarantees this does not occur.
- REQ-023 Checkpoints SHALL form a circular buffer (head = oldest, tail = next free); ckpt_id SHALL equal the tail.
- REQ-024 A ckpt_req while ckpt_full=0 SHALL snapshot the table's next state (including same-cycle renames and CDB updates) into slot tail, then increment tail.
- REQ-025 ckpt_full SHALL equal (ckpt_count == NRCKPT); a ckpt_req while full SHALL be ignored with no state change.
- REQ-026 ckpt_release with ckpt_count>0 SHALL advance head; a release when empty SHALL be ignored.
- REQ-027 restore_valid with a live restore_id SHALL load the table from that snapshot (plus same-cycle CDB updates), set tail=restore_id+1 mod NRCKPT, and discard younger checkpoints.
- REQ-028 restore_valid with a non-live restore_id SHALL be ignored.
- REQ-029 Same-cycle priority: restore over rename and ckpt_req, both of which are dropped; a same-cycle ckpt_release still applies, unless it would free the restored slot, in which case the restore is ignored.
- REQ-030 ckpt_req and ckpt_release in the same cycle while full SHALL both take effect (release first).
- REQ-031 Pointer arithmetic SHALL wrap modulo NRCKPT; NRCKPT SHALL be a power of 2.

Reset
- REQ-032 rst SHALL set all entries to Valid=1, Tag=0, Value=0; head=tail=0; ckpt_count=0; ckpt_full=0; ckpt_id=0.
- REQ-033 rst asserted mid-operation SHALL discard all pending renames and checkpoints, and snapshot contents become don't-care.

Structure
- REQ-034 RAT_t {Valid, Tag[TAG_W], Value[BITWIDTH]} and the default parameter constants SHALL live in OoO_packages.
- REQ-035 The CDB match-and-update logic SHALL be one sub-module, rat_cdb_update, instantiated for the live table and for each snapshot.

Verification
- REQ-036 Reset, then read r5 -> Valid=1, Tag=0, Value=0; read r0 -> zero.
- REQ-037 Rename r3->tag 7; next cycle read r3 -> Valid=0, Tag=7; cdb tag 7 value 0xAB -> same-cycle read Valid=1, Value=0xAB; next cycle the stored entry equals the same.
- REQ-038 Both rename ports target r4 with tags 1 and 2 in one cycle -> r4.Tag=2; rename r4->9 plus cdb tag 2 in the same cycle -> r4 Valid=0, Tag=9.
- REQ-039 Four ckpt_req -> ckpt_full=1, ckpt_count=4; fifth request ignored; request and release in the same cycle -> count stays 4, ckpt_id wraps to 0.
- REQ-040 Rename r6->3; checkpoint id 0; rename r6->5; cdb tag 3 value 0x11; restore 0 -> r6 Valid=1, Value=0x11; ckpt_count=1.
- REQ-041 Assert rst between ckpt_req and restore -> all state returns to reset values and the later restore_id 0 is ignored.

Source files
------------

// File: rtl/OoO_packages.sv
`default_nettype none
// ============================================================================
// Module  : OoO_packages
// Brief   : Shared rename-table entry type and default sizing constants.
// Revision: 1.0
// ============================================================================
package OoO_packages;

   localparam int NRREG_DEF    = 32;
   localparam int BITWIDTH_DEF = 32;
   localparam int TAG_W_DEF    = 6;
   localparam int NRREAD_DEF   = 4;
   localparam int NRRENAME_DEF = 2;
   localparam int NRCDB_DEF    = 2;
   localparam int NRCKPT_DEF   = 4;

   // Valid=1: Value is usable; Valid=0: the value is pending on Tag.
   typedef struct packed {
      logic                    Valid;
      logic [TAG_W_DEF-1:0]    Tag;
      logic [BITWIDTH_DEF-1:0] Value;
   } RAT_t;

   localparam RAT_t RAT_RESET = '{Valid: 1'b1, Tag: '0, Value: '0};

endpackage
`default_nettype wire

// File: rtl/rat_cdb_update.sv
`default_nettype none
// ============================================================================
// Module  : rat_cdb_update
// Brief   : Resolves one pending rename entry against the CDB broadcasts.
// Revision: 1.0
// ============================================================================
module rat_cdb_update
   import OoO_packages::*;
#(
   parameter int NRCDB    = NRCDB_DEF,
   parameter int TAG_W    = TAG_W_DEF,
   parameter int BITWIDTH = BITWIDTH_DEF
) (
   input  RAT_t                i_entry,
   input  logic                i_cdb_valid [NRCDB],
   input  logic [TAG_W-1:0]    i_cdb_tag   [NRCDB],
   input  logic [BITWIDTH-1:0] i_cdb_value [NRCDB],
   output RAT_t                o_entry
);

   // Scanning downwards lets the lowest-index matching port have the last word.
   always_comb begin
      o_entry = i_entry;
      if (!i_entry.Valid) begin
         for (int i = NRCDB - 1; i >= 0; i--) begin
            if (i_cdb_valid[i] && (i_cdb_tag[i] == i_entry.Tag)) begin
               o_entry.Valid = 1'b1;
               o_entry.Value = i_cdb_value[i];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rename_table.sv
`default_nettype none
// ============================================================================
// Module  : rename_table
// Brief   : Register alias table with CDB forwarding and circular checkpoints.
// Revision: 1.0
// ============================================================================
module rename_table
   import OoO_packages::*;
#(
   parameter int NRREG    = NRREG_DEF,
   parameter int BITWIDTH = BITWIDTH_DEF,
   parameter int TAG_W    = TAG_W_DEF,
   parameter int NRREAD   = NRREAD_DEF,
   parameter int NRRENAME = NRRENAME_DEF,
   parameter int NRCDB    = NRCDB_DEF,
   parameter int NRCKPT   = NRCKPT_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(NRREG)-1:0]   rd_addr       [NRREAD],
   output RAT_t                       rd_data       [NRREAD],
   input  logic                       ren_valid     [NRRENAME],
   input  logic [$clog2(NRREG)-1:0]   ren_addr      [NRRENAME],
   input  logic [TAG_W-1:0]           ren_tag       [NRRENAME],
   input  logic                       cdb_valid     [NRCDB],
   input  logic [TAG_W-1:0]           cdb_tag       [NRCDB],
   input  logic [BITWIDTH-1:0]        cdb_value     [NRCDB],
   input  logic                       ckpt_req,
   output logic [$clog2(NRCKPT)-1:0]  ckpt_id,
   output logic                       ckpt_full,
   input  logic                       ckpt_release,
   input  logic                       restore_valid,
   input  logic [$clog2(NRCKPT)-1:0]  restore_id,
   output logic [$clog2(NRCKPT):0]    ckpt_count
);

   localparam int PW = $clog2(NRCKPT);
   localparam int CW = PW + 1;

   RAT_t tab_q    [NRREG];
   RAT_t tab_d    [NRREG];
   RAT_t tab_fwd  [NRREG];
   RAT_t snap_q   [NRCKPT][NRREG];
   RAT_t snap_d   [NRCKPT][NRREG];
   RAT_t snap_fwd [NRCKPT][NRREG];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          release_ok;
   logic          restore_ok;
   logic          alloc_ok;
   logic [PW-1:0] restore_off;

   for (genvar r = 0; r < NRREG; r++) begin : g_tab
      rat_cdb_update #(.NRCDB(NRCDB), .TAG_W(TAG_W), .BITWIDTH(BITWIDTH)) u_tab_upd (
         .i_entry     (tab_q[r]),
         .i_cdb_valid (cdb_valid),
         .i_cdb_tag   (cdb_tag),
         .i_cdb_value (cdb_value),
         .o_entry     (tab_fwd[r])
      );
      for (genvar k = 0; k < NRCKPT; k++) begin : g_snap
         rat_cdb_update #(.NRCDB(NRCDB), .TAG_W(TAG_W), .BITWIDTH(BITWIDTH)) u_snap_upd (
            .i_entry     (snap_q[k][r]),
            .i_cdb_valid (cdb_valid),
            .i_cdb_tag   (cdb_tag),
            .i_cdb_value (cdb_value),
            .o_entry     (snap_fwd[k][r])
         );
      end
   end

   always_comb begin
      for (int p = 0; p < NRREAD; p++) begin
         rd_data[p] = (rd_addr[p] == '0) ? RAT_RESET : tab_fwd[rd_addr[p]];
      end
   end

   always_comb begin
      release_ok  = ckpt_release && (count_q != '0);
      restore_off = restore_id - head_q;
      // A restore whose slot is being freed in the same cycle cannot be honoured.
      restore_ok  = restore_valid && ({1'b0, restore_off} < count_q)
                    && !(release_ok && (restore_id == head_q));
      alloc_ok    = ckpt_req && !restore_ok
                    && ((count_q != CW'(NRCKPT)) || release_ok);

      tab_d   = tab_fwd;
      snap_d  = snap_fwd;
      head_d  = head_q + PW'(release_ok);
      tail_d  = tail_q;
      count_d = count_q - CW'(release_ok);

      if (restore_ok) begin
         tab_d   = snap_fwd[restore_id];
         tail_d  = restore_id + PW'(1);
         count_d = CW'(restore_off) + CW'(1) - CW'(release_ok);
      end else begin
         // Ascending order: the highest-index port writing a register wins.
         for (int j = 0; j < NRRENAME; j++) begin
            if (ren_valid[j] && (ren_addr[j] != '0)) begin
               tab_d[ren_addr[j]].Valid = 1'b0;
               tab_d[ren_addr[j]].Tag   = ren_tag[j];
            end
         end
         if (alloc_ok) begin
            snap_d[tail_q] = tab_d;
            tail_d         = tail_q + PW'(1);
            count_d        = count_q + CW'(1) - CW'(release_ok);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NRREG; r++) begin
            tab_q[r] <= RAT_RESET;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         tab_q   <= tab_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Snapshot contents are meaningless once their slot is dead, so no reset.
   always_ff @(posedge clk) begin
      snap_q <= snap_d;
   end

   assign ckpt_id    = tail_q;
   assign ckpt_full  = (count_q == CW'(NRCKPT));
   assign ckpt_count = count_q;

endmodule
`default_nettype wire
